// File: rtl/scanout_reader_pkg.sv
// Shared frame-buffer definitions for the scanout path: default raster size,
// burst field width, RGB565 black and the scanout FSM state encoding.
package scanout_reader_pkg;

  localparam int unsigned H_ACTIVE_DEF   = 640;
  localparam int unsigned V_ACTIVE_DEF   = 480;
  localparam int unsigned BURST_BITS_DEF = 10;

  localparam logic [15:0] RGB565_BLACK = 16'h0000;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_SPACE = 3'd1,
    REQ        = 3'd2,
    DATA       = 3'd3,
    FLUSH      = 3'd4
  } state_t;

endpackage

// File: rtl/scanout_reader_fifo.sv
// scanout_fifo: synchronous pixel FIFO with clear, combinational head read and
// free-space count; a word pushed on one edge is visible to pop the next cycle.
module scanout_fifo #(
  parameter  int unsigned DEPTH = 256,
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [AW:0]      free_count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      used;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  assign used       = wr_ptr - rd_ptr;
  assign empty      = (used == '0);
  assign free_count = (AW+1)'(DEPTH) - used;
  assign full       = (free_count == '0);
  assign push_ok    = push && !full;
  assign pop_ok     = pop && !empty;
  assign dout       = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/scanout_reader.sv
// Frame-buffer scanout engine: sequential SDRAM read bursts into a line FIFO,
// one pixel per display request. Optional SCANOUT_UNDERFLOW_CNT_EN adds underflow_cnt.
module scanout_reader
  import scanout_reader_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned BURST_BITS = BURST_BITS_DEF,
  parameter int unsigned BURST_LEN  = 64,
  parameter int unsigned FIFO_DEPTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  frame_start,
  input  logic [1:0]            bank,
  output logic                  read_burst_req,
  output logic [23:0]           addr,
  output logic [1:0]            read_bank,
  output logic [BURST_BITS-1:0] read_burst_len,
  input  logic                  read_burst_data_valid,
  input  logic [15:0]           read_burst_data,
  input  logic                  read_burst_finish,
  input  logic                  pixel_req,
  output logic [15:0]           pixel,
  output logic                  pixel_valid,
  output logic                  underflow
`ifdef SCANOUT_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]           underflow_cnt
`endif
);

  localparam int unsigned FCW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [23:0] FRAME_WORDS = 24'(H_ACTIVE * V_ACTIVE);

  state_t                state;
  state_t                next_state;
  logic [23:0]           word_addr;
  logic [23:0]           word_addr_d;
  logic [23:0]           remaining;
  logic [23:0]           addr_d;
  logic [BURST_BITS-1:0] burst_words;
  logic [BURST_BITS-1:0] len_d;
  logic [1:0]            read_bank_d;
  logic                  req_d;
  logic                  can_req;
  logic                  restart_pending;
  logic                  restart_pending_d;
  logic                  fifo_clear;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_empty;
  logic [15:0]           fifo_dout;
  logic [FCW-1:0]        free_count;
  logic                  pop_empty;
  logic [15:0]           pixel_d;
  logic                  pixel_valid_d;
  logic                  underflow_d;

  assign remaining   = FRAME_WORDS - word_addr;
  assign burst_words = (remaining < 24'(BURST_LEN)) ? BURST_BITS'(remaining)
                                                    : BURST_BITS'(BURST_LEN);
  assign can_req     = enable && (remaining != '0) && (free_count >= FCW'(BURST_LEN));

  scanout_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (fifo_clear),
    .push       (fifo_push),
    .din        (read_burst_data),
    .pop        (fifo_pop),
    .dout       (fifo_dout),
    .empty      (fifo_empty),
    .free_count (free_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // A burst is never aborted: a restart seen in DATA waits for the finish pulse.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:       if (frame_start) next_state = FLUSH;
      FLUSH:      next_state = WAIT_SPACE;
      WAIT_SPACE: if (frame_start) next_state = FLUSH;
                  else if (can_req) next_state = REQ;
      REQ:        next_state = frame_start ? FLUSH : DATA;
      DATA:       if (read_burst_finish)
                    next_state = (restart_pending || frame_start) ? FLUSH : WAIT_SPACE;
      default:    next_state = IDLE;
    endcase
  end

  // Burst outputs are registered from next_state so the request rises on the edge entering REQ.
  always_comb begin
    req_d             = (next_state == REQ) || (next_state == DATA);
    addr_d            = addr;
    len_d             = read_burst_len;
    word_addr_d       = word_addr;
    read_bank_d       = read_bank;
    restart_pending_d = (state == DATA) && (next_state == DATA) &&
                        (restart_pending || frame_start);
    fifo_clear        = (state == FLUSH);
    fifo_push         = (state == DATA) && read_burst_data_valid &&
                        !frame_start && !restart_pending;
    fifo_pop          = pixel_req && !frame_start && !fifo_empty;
    pop_empty         = pixel_req && !frame_start && fifo_empty;
    pixel_d           = fifo_pop ? fifo_dout : RGB565_BLACK;
    pixel_valid_d     = fifo_pop;
    underflow_d       = ((state == FLUSH) ? 1'b0 : underflow) | pop_empty;
    if (state == WAIT_SPACE && next_state == REQ) begin
      addr_d = word_addr;
      len_d  = burst_words;
    end
    if (state == FLUSH) begin
      word_addr_d = '0;
      read_bank_d = bank;
    end else if (state == DATA && read_burst_finish) begin
      word_addr_d = word_addr + {{(24-BURST_BITS){1'b0}}, read_burst_len};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      read_burst_req  <= 1'b0;
      addr            <= '0;
      read_burst_len  <= '0;
      read_bank       <= '0;
      word_addr       <= '0;
      restart_pending <= 1'b0;
      pixel           <= RGB565_BLACK;
      pixel_valid     <= 1'b0;
      underflow       <= 1'b0;
    end else begin
      read_burst_req  <= req_d;
      addr            <= addr_d;
      read_burst_len  <= len_d;
      read_bank       <= read_bank_d;
      word_addr       <= word_addr_d;
      restart_pending <= restart_pending_d;
      pixel           <= pixel_d;
      pixel_valid     <= pixel_valid_d;
      underflow       <= underflow_d;
    end
  end

`ifdef SCANOUT_UNDERFLOW_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                                underflow_cnt <= '0;
    else if (pop_empty && underflow_cnt != '1) underflow_cnt <= underflow_cnt + 16'd1;
  end
`endif

endmodule
